// File: rtl/misr_trace_pkg.sv
// Shared constants and word packing for the MISR trace collector.
// Optional drop counter is enabled with MISR_TRACE_DROP_CNT_EN.
package misr_trace_pkg;

  localparam int unsigned DEF_NBIT_DATA  = 64;
  localparam int unsigned DEF_NR_PORTS   = 2;
  localparam int unsigned DEF_FIFO_DEPTH = 8;
  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned PTR_W          = $clog2(DEF_FIFO_DEPTH);
  localparam int unsigned OCC_W          = $clog2(DEF_FIFO_DEPTH + 1);

  // Rotating by port+1 keeps identical data on different ports distinguishable.
  function automatic logic [DEF_NBIT_DATA-1:0] pack_word(
    input logic [DEF_NBIT_DATA-1:0] pc,
    input logic [DEF_NBIT_DATA-1:0] wdata,
    input int unsigned              port
  );
    int unsigned sh;
    sh = (port + 1) % DEF_NBIT_DATA;
    if (sh == 0) return pc ^ wdata;
    return pc ^ ((wdata << sh) | (wdata >> (DEF_NBIT_DATA - sh)));
  endfunction

endpackage

// File: rtl/misr_trace_fifo.sv
// Multi-push, single-pop FIFO; pushes are taken in port order up to the free
// slots, where a same-cycle pop already counts as a free slot.
module misr_trace_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned NPUSH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [NPUSH-1:0]                   push,
  input  logic [NPUSH-1:0][WIDTH-1:0]        push_data,
  input  logic                               ready,
  output logic [WIDTH-1:0]                   data,
  output logic                               valid,
  output logic                               empty,
  output logic [$clog2(DEPTH+1)-1:0]         count,
  output logic [$clog2(NPUSH+1)-1:0]         dropped
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(NPUSH + 1);

  logic [WIDTH-1:0]           mem [DEPTH];
  logic [PW-1:0]              rd_ptr;
  logic [PW-1:0]              wr_ptr;
  logic                       pop;
  logic [CW-1:0]              free;
  logic [AW-1:0]              accepted;
  logic [NPUSH-1:0]           wen;
  logic [NPUSH-1:0][PW-1:0]   waddr;

  assign empty = (count == '0);
  assign valid = !empty;
  assign data  = empty ? '0 : mem[rd_ptr];
  assign pop   = valid && ready && !flush;
  assign free  = CW'(DEPTH) - count + CW'(pop);

  // Assign consecutive slots to requesting ports, lowest index first.
  always_comb begin
    accepted = '0;
    dropped  = '0;
    wen      = '0;
    waddr    = '0;
    for (int unsigned p = 0; p < NPUSH; p++) begin
      if (push[p] && !flush) begin
        if (CW'(accepted) < free) begin
          wen[p]   = 1'b1;
          waddr[p] = wr_ptr + PW'(accepted);
          accepted = accepted + 1'b1;
        end else begin
          dropped = dropped + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(accepted);
      count  <= count + CW'(accepted) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < NPUSH; p++) begin
      if (wen[p]) mem[waddr[p]] <= push_data[p];
    end
  end

endmodule

// File: rtl/misr_trace_collector.sv
// Compacts commit-port activity into MISR words and streams them out.
// Define MISR_TRACE_DROP_CNT_EN to add the saturating drop_cnt_o counter.
module misr_trace_collector
  import misr_trace_pkg::*;
#(
  parameter int unsigned NBIT_DATA  = DEF_NBIT_DATA,
  parameter int unsigned NR_PORTS   = DEF_NR_PORTS,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                en_i,
  input  logic                                flush_i,
  input  logic [NR_PORTS-1:0]                 commit_valid_i,
  input  logic [NR_PORTS-1:0][NBIT_DATA-1:0]  commit_pc_i,
  input  logic [NR_PORTS-1:0][NBIT_DATA-1:0]  commit_wdata_i,
  output logic [NBIT_DATA-1:0]                data_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic                                empty_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count_o,
  output logic                                overflow_o
`ifdef MISR_TRACE_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0]                    drop_cnt_o
`endif
);

  localparam int unsigned DW = $clog2(NR_PORTS + 1);

  logic [NR_PORTS-1:0][NBIT_DATA-1:0] words;
  logic [NR_PORTS-1:0]                push;
  logic [DW-1:0]                      dropped;

  for (genvar i = 0; i < NR_PORTS; i++) begin : g_word
    assign words[i] = pack_word(commit_pc_i[i], commit_wdata_i[i], i);
  end

  assign push = commit_valid_i & {NR_PORTS{en_i && !flush_i}};

  misr_trace_fifo #(
    .WIDTH (NBIT_DATA),
    .DEPTH (FIFO_DEPTH),
    .NPUSH (NR_PORTS)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (flush_i),
    .push      (push),
    .push_data (words),
    .ready     (ready_i),
    .data      (data_o),
    .valid     (valid_o),
    .empty     (empty_o),
    .count     (count_o),
    .dropped   (dropped)
  );

  // Sticky loss flag, cleared only by flush or reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              overflow_o <= 1'b0;
    else if (flush_i)       overflow_o <= 1'b0;
    else if (dropped != '0) overflow_o <= 1'b1;
  end

`ifdef MISR_TRACE_DROP_CNT_EN
  localparam int unsigned SW = CNT_W + 1;

  logic [CNT_W:0] drop_sum;

  assign drop_sum = {1'b0, drop_cnt_o} + SW'(dropped);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)             drop_cnt_o <= '0;
    else if (flush_i)      drop_cnt_o <= '0;
    else if (drop_sum[CNT_W]) drop_cnt_o <= '1;
    else                   drop_cnt_o <= drop_sum[CNT_W-1:0];
  end
`endif

endmodule

// File: tb/tb_misr_trace_collector.sv
// Randomized scoreboard bench for misr_trace_collector against a queue model.
module tb_misr_trace_collector;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             flush;
  logic [1:0]       cv;
  logic [1:0][63:0] pc;
  logic [1:0][63:0] wd;
  logic [63:0]      data;
  logic             valid;
  logic             ready;
  logic             empty;
  logic [3:0]       count;
  logic             overflow;
  logic [15:0]      drop_cnt;

  int tests  = 0;
  int errors = 0;

  // Reference state: occupancy, sticky flag, drop total, expected words in order.
  int          occ  = 0;
  bit          ovf  = 1'b0;
  int          dcnt = 0;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  misr_trace_collector dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .en_i           (en),
    .flush_i        (flush),
    .commit_valid_i (cv),
    .commit_pc_i    (pc),
    .commit_wdata_i (wd),
    .data_o         (data),
    .valid_o        (valid),
    .ready_i        (ready),
    .empty_o        (empty),
    .count_o        (count),
    .overflow_o     (overflow)
`ifdef MISR_TRACE_DROP_CNT_EN
    ,
    .drop_cnt_o     (drop_cnt)
`endif
  );

`ifndef MISR_TRACE_DROP_CNT_EN
  assign drop_cnt = '0;
`endif

  function automatic logic [63:0] ref_word(logic [63:0] p, logic [63:0] w, int port);
    logic [63:0] r;
    for (int b = 0; b < 64; b++) r[(b + port + 1) % 64] = w[b];
    return p ^ r;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Effect of the inputs seen at this clock edge on the reference state.
  task automatic model_edge();
    int pop, free, acc, drop;
    if (flush) begin
      occ = 0; ovf = 1'b0; dcnt = 0;
      exp_q.delete();
      return;
    end
    pop  = (occ > 0 && ready) ? 1 : 0;
    free = 8 - occ + pop;
    acc  = 0;
    drop = 0;
    if (en) begin
      for (int p = 0; p < 2; p++) begin
        if (cv[p]) begin
          if (acc < free) begin
            exp_q.push_back(ref_word(pc[p], wd[p], p));
            acc++;
          end else begin
            drop++;
          end
        end
      end
    end
    occ = occ + acc - pop;
    if (drop > 0) ovf = 1'b1;
    dcnt = (dcnt + drop > 65535) ? 65535 : dcnt + drop;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic set_in(bit e, bit f, bit [1:0] v, logic [63:0] p0, logic [63:0] w0,
                        logic [63:0] p1, logic [63:0] w1, bit r);
    en = e; flush = f; cv = v; ready = r;
    pc[0] = p0; wd[0] = w0; pc[1] = p1; wd[1] = w1;
  endtask

  task automatic idle(bit r, int n);
    set_in(1'b1, 1'b0, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0, r);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic dual_rand(bit r, int n);
    for (int i = 0; i < n; i++) begin
      set_in(1'b1, 1'b0, 2'b11, rnd64(), rnd64(), rnd64(), rnd64(), r);
      step();
    end
  endtask

  // Monitor: checks status every cycle and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    chk("count", 64'(count), 64'(occ));
    chk("valid", 64'(valid), 64'(occ != 0));
    chk("empty", 64'(empty), 64'(occ == 0));
    chk("overflow", 64'(overflow), 64'(ovf));
`ifdef MISR_TRACE_DROP_CNT_EN
    chk("drop_cnt", 64'(drop_cnt), 64'(dcnt));
`endif
    if (occ == 0) chk("idle_data", data, 64'h0);
    if (valid && ready && !flush && !rst) begin
      if (exp_q.size() == 0) chk("unexpected_pop", 64'(valid), 64'h0);
      else chk("data", data, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1;
    set_in(1'b0, 1'b0, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0);
    step(); step();
    rst = 1'b0;
    idle(1'b1, 3);

    // Single port commit, then dual commit with identical-looking data.
    set_in(1'b1, 1'b0, 2'b01, 64'h1000, 64'h1, 64'h0, 64'h0, 1'b1);
    step();
    idle(1'b1, 2);
    set_in(1'b1, 1'b0, 2'b11, 64'h2000, 64'h0, 64'h2004, 64'h1, 1'b0);
    step();
    idle(1'b1, 3);

    // Overflow, full FIFO with pop, then drain.
    dual_rand(1'b0, 5);
    dual_rand(1'b1, 1);
    idle(1'b1, 10);

    // Flush with count 5, sticky overflow, commit and ready all present.
    dual_rand(1'b0, 5);
    idle(1'b1, 3);
    set_in(1'b1, 1'b1, 2'b11, rnd64(), rnd64(), rnd64(), rnd64(), 1'b1);
    step();
    idle(1'b1, 2);

    // Asynchronous reset mid-burst.
    dual_rand(1'b0, 3);
    rst = 1'b1;
    occ = 0; ovf = 1'b0; dcnt = 0;
    exp_q.delete();
    dual_rand(1'b1, 2);
    rst = 1'b0;
    idle(1'b0, 3);

    // Randomized traffic with occasional flushes and stalls.
    for (int c = 0; c < 800; c++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 2'($urandom),
             rnd64(), rnd64(), rnd64(), ($urandom_range(0, 3) == 0) ? 64'h0 : rnd64(),
             $urandom_range(0, 9) < 6);
      step();
    end

    idle(1'b1, 12);
    chk("leftover", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
